// File: rtl/muovi_quadrato_pkg.sv
// Shared constants for the bouncing box: active area, reset placement, FSM encoding
// and the per-axis bounce step used by the motion block.
package muovi_quadrato_pkg;

    localparam int H_ATTIVO      = 1280;
    localparam int V_ATTIVO      = 1024;
    localparam int LARGHEZZA_DEF = 100;
    localparam int ALTEZZA_DEF   = 100;
    localparam int POS_W         = 11;
    localparam int CALC_W        = 12;

    typedef enum logic [1:0] {
        ATTESA = 2'd0,
        CALC_X = 2'd1,
        CALC_Y = 2'd2,
        SCRIVI = 2'd3
    } stato_t;

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic             dir;
    } asse_t;

    function automatic logic [POS_W-1:0] pos_centro(input int totale, input int lato);
        return POS_W'((totale - lato) / 2);
    endfunction

    localparam logic [POS_W-1:0] X_RESET = pos_centro(H_ATTIVO, LARGHEZZA_DEF);
    localparam logic [POS_W-1:0] Y_RESET = pos_centro(V_ATTIVO, ALTEZZA_DEF);

    // A box that would reach or cross the far wall is parked exactly on it and turns
    // around in the same update, so it never sits on the wall still heading outward.
    function automatic asse_t passo_asse(
        input asse_t             cur,
        input logic [CALC_W-1:0] limite,
        input logic [CALC_W-1:0] lato,
        input logic [CALC_W-1:0] passo
    );
        logic [CALC_W-1:0] p;
        asse_t             nxt;
        p   = {1'b0, cur.pos};
        nxt = cur;
        if (cur.dir) begin
            if (p + lato + passo >= limite) begin
                nxt.pos = POS_W'(limite - lato);
                nxt.dir = 1'b0;
            end else begin
                nxt.pos = POS_W'(p + passo);
            end
        end else begin
            if (p < passo) begin
                nxt.pos = '0;
                nxt.dir = 1'b1;
            end else begin
                nxt.pos = POS_W'(p - passo);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/muovi_quadrato_rileva_fronte.sv
// Rising-edge detector on an already-synchronous level; pulse is combinational, one cycle wide.
// The first cycle after reset never reports an edge, even if the level is already high.
module rileva_fronte (
    input  logic clk,
    input  logic rst,
    input  logic livello,
    output logic fronte
);

    logic livello_q, livello_d;
    logic armato_q, armato_d;

    always_comb begin
        livello_d = livello;
        armato_d  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            livello_q <= 1'b0;
            armato_q  <= 1'b0;
        end else begin
            livello_q <= livello_d;
            armato_q  <= armato_d;
        end
    end

    assign fronte = livello & ~livello_q & armato_q;

endmodule

// File: rtl/muovi_quadrato.sv
// Moves the box by PASSO on each axis every FRAME_DIV vsync edges, bouncing off the borders.
// New position appears three clocks after the edge is sampled, with a one-cycle AGGIORNATO pulse.
module muovi_quadrato #(
    parameter int H         = muovi_quadrato_pkg::H_ATTIVO,
    parameter int V         = muovi_quadrato_pkg::V_ATTIVO,
    parameter int larghezza = muovi_quadrato_pkg::LARGHEZZA_DEF,
    parameter int altezza   = muovi_quadrato_pkg::ALTEZZA_DEF,
    parameter int PASSO     = 2,
    parameter int FRAME_DIV = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FRAME,
    input  logic        PAUSA,
    output logic [10:0] X_POS,
    output logic [10:0] Y_POS,
    output logic        DIR_X,
    output logic        DIR_Y,
    output logic        AGGIORNATO
);

    import muovi_quadrato_pkg::*;

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(FRAME_DIV - 1);
    localparam logic [CALC_W-1:0] H_C     = CALC_W'(H);
    localparam logic [CALC_W-1:0] V_C     = CALC_W'(V);
    localparam logic [CALC_W-1:0] LARG_C  = CALC_W'(larghezza);
    localparam logic [CALC_W-1:0] ALT_C   = CALC_W'(altezza);
    localparam logic [CALC_W-1:0] PASSO_C = CALC_W'(PASSO);
    localparam logic [POS_W-1:0]  X_INIZ  = pos_centro(H, larghezza);
    localparam logic [POS_W-1:0]  Y_INIZ  = pos_centro(V, altezza);

    logic fronte;

    stato_t           stato_q, stato_d;
    logic [DIV_W-1:0] div_q, div_d;
    asse_t            x_q, x_d, y_q, y_d;
    asse_t            x_sh_q, x_sh_d, y_sh_q, y_sh_d;
    logic             agg_q, agg_d;

    rileva_fronte u_fronte (
        .clk     (CLK),
        .rst     (RST),
        .livello (FRAME),
        .fronte  (fronte)
    );

    // Edges are only looked at in ATTESA; anything arriving mid-update is dropped.
    always_comb begin
        stato_d = stato_q;
        div_d   = div_q;
        x_d     = x_q;
        y_d     = y_q;
        x_sh_d  = x_sh_q;
        y_sh_d  = y_sh_q;
        agg_d   = 1'b0;
        case (stato_q)
            ATTESA: begin
                if (fronte && !PAUSA) begin
                    if (div_q == DIV_MAX) begin
                        div_d   = '0;
                        stato_d = CALC_X;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end
            CALC_X: begin
                x_sh_d  = passo_asse(x_q, H_C, LARG_C, PASSO_C);
                stato_d = CALC_Y;
            end
            CALC_Y: begin
                y_sh_d  = passo_asse(y_q, V_C, ALT_C, PASSO_C);
                stato_d = SCRIVI;
            end
            SCRIVI: begin
                x_d     = x_sh_q;
                y_d     = y_sh_q;
                agg_d   = 1'b1;
                stato_d = ATTESA;
            end
            default: stato_d = ATTESA;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stato_q <= ATTESA;
            div_q   <= '0;
            x_q     <= '{pos: X_INIZ, dir: 1'b1};
            y_q     <= '{pos: Y_INIZ, dir: 1'b1};
            x_sh_q  <= '{pos: X_INIZ, dir: 1'b1};
            y_sh_q  <= '{pos: Y_INIZ, dir: 1'b1};
            agg_q   <= 1'b0;
        end else begin
            stato_q <= stato_d;
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x_sh_q  <= x_sh_d;
            y_sh_q  <= y_sh_d;
            agg_q   <= agg_d;
        end
    end

    assign X_POS      = x_q.pos;
    assign Y_POS      = y_q.pos;
    assign DIR_X      = x_q.dir;
    assign DIR_Y      = y_q.dir;
    assign AGGIORNATO = agg_q;

endmodule

// File: tb/tb_muovi_quadrato.sv
// Directed bench: default box (a), 99x99 box reaching odd positions (b), FRAME_DIV=3 (c).
module tb_muovi_quadrato;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic        rst_a = 1'b1, frame_a = 1'b0, pausa_a = 1'b0;
    logic        rst_b = 1'b1, frame_b = 1'b0, pausa_b = 1'b0;
    logic        rst_c = 1'b1, frame_c = 1'b0, pausa_c = 1'b0;
    logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic        dx_a, dy_a, agg_a, dx_b, dy_b, agg_b, dx_c, dy_c, agg_c;

    muovi_quadrato dut_a (
        .CLK(clk), .RST(rst_a), .FRAME(frame_a), .PAUSA(pausa_a),
        .X_POS(x_a), .Y_POS(y_a), .DIR_X(dx_a), .DIR_Y(dy_a), .AGGIORNATO(agg_a)
    );

    muovi_quadrato #(.larghezza(99), .altezza(99)) dut_b (
        .CLK(clk), .RST(rst_b), .FRAME(frame_b), .PAUSA(pausa_b),
        .X_POS(x_b), .Y_POS(y_b), .DIR_X(dx_b), .DIR_Y(dy_b), .AGGIORNATO(agg_b)
    );

    muovi_quadrato #(.FRAME_DIV(3)) dut_c (
        .CLK(clk), .RST(rst_c), .FRAME(frame_c), .PAUSA(pausa_c),
        .X_POS(x_c), .Y_POS(y_c), .DIR_X(dx_c), .DIR_Y(dy_c), .AGGIORNATO(agg_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_a(input int n);
        for (int i = 0; i < n; i++) begin
            frame_a = 1'b1;
            tick();
            frame_a = 1'b0;
            repeat (5) tick();
        end
    endtask

    task automatic step_b(input int n);
        for (int i = 0; i < n; i++) begin
            frame_b = 1'b1;
            tick();
            frame_b = 1'b0;
            repeat (5) tick();
        end
    endtask

    task automatic test_reset();
        int agg_n;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        frame_a = 1'b1;
        tick(); tick();
        n_chk++; if (x_a !== 11'd590) $display("FAIL rst_x: got %0d expected 590", x_a); else n_pass++;
        n_chk++; if (y_a !== 11'd462) $display("FAIL rst_y: got %0d expected 462", y_a); else n_pass++;
        n_chk++; if (dx_a !== 1'b1) $display("FAIL rst_dx: got %b expected 1", dx_a); else n_pass++;
        n_chk++; if (dy_a !== 1'b1) $display("FAIL rst_dy: got %b expected 1", dy_a); else n_pass++;
        n_chk++; if (agg_a !== 1'b0) $display("FAIL rst_agg: got %b expected 0", agg_a); else n_pass++;
        n_chk++; if (x_b !== 11'd590 || y_b !== 11'd462)
            $display("FAIL rst_b_pos: got %0d/%0d expected 590/462", x_b, y_b); else n_pass++;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        agg_n = 0;
        repeat (6) begin
            tick();
            if (agg_a === 1'b1) agg_n++;
        end
        n_chk++; if (agg_n != 0) $display("FAIL frame_high_after_rst_agg: got %0d pulses expected 0", agg_n); else n_pass++;
        n_chk++; if (x_a !== 11'd590) $display("FAIL frame_high_after_rst_x: got %0d expected 590", x_a); else n_pass++;
        frame_a = 1'b0;
        tick();
    endtask

    task automatic test_single_update();
        frame_a = 1'b1;
        tick();
        frame_a = 1'b0;
        tick(); tick();
        n_chk++; if (agg_a !== 1'b0) $display("FAIL upd_early_agg: got %b expected 0", agg_a); else n_pass++;
        n_chk++; if (x_a !== 11'd590) $display("FAIL upd_early_x: got %0d expected 590", x_a); else n_pass++;
        tick();
        n_chk++; if (x_a !== 11'd592) $display("FAIL upd_x: got %0d expected 592", x_a); else n_pass++;
        n_chk++; if (y_a !== 11'd464) $display("FAIL upd_y: got %0d expected 464", y_a); else n_pass++;
        n_chk++; if (agg_a !== 1'b1) $display("FAIL upd_agg: got %b expected 1", agg_a); else n_pass++;
        n_chk++; if (dx_a !== 1'b1 || dy_a !== 1'b1)
            $display("FAIL upd_dir: got %b/%b expected 1/1", dx_a, dy_a); else n_pass++;
        tick();
        n_chk++; if (agg_a !== 1'b0) $display("FAIL upd_agg_width: got %b expected 0", agg_a); else n_pass++;
        n_chk++; if (x_a !== 11'd592) $display("FAIL upd_hold_x: got %0d expected 592", x_a); else n_pass++;
    endtask

    task automatic test_pause();
        int agg_n;
        pausa_a = 1'b1;
        agg_n = 0;
        repeat (5) begin
            frame_a = 1'b1;
            tick();
            if (agg_a === 1'b1) agg_n++;
            frame_a = 1'b0;
            repeat (5) begin
                tick();
                if (agg_a === 1'b1) agg_n++;
            end
        end
        n_chk++; if (agg_n != 0) $display("FAIL pause_agg: got %0d pulses expected 0", agg_n); else n_pass++;
        n_chk++; if (x_a !== 11'd592) $display("FAIL pause_x: got %0d expected 592", x_a); else n_pass++;
        n_chk++; if (y_a !== 11'd464) $display("FAIL pause_y: got %0d expected 464", y_a); else n_pass++;
        pausa_a = 1'b0;
        frame_a = 1'b1;
        tick();
        frame_a = 1'b0;
        repeat (3) tick();
        n_chk++; if (x_a !== 11'd594) $display("FAIL resume_x: got %0d expected 594", x_a); else n_pass++;
        n_chk++; if (y_a !== 11'd466) $display("FAIL resume_y: got %0d expected 466", y_a); else n_pass++;
        n_chk++; if (agg_a !== 1'b1) $display("FAIL resume_agg: got %b expected 1", agg_a); else n_pass++;
        repeat (2) tick();
    endtask

    task automatic test_bounce_right();
        step_a(292);
        n_chk++; if (x_a !== 11'd1178 || dx_a !== 1'b1)
            $display("FAIL pre_right_x: got %0d dir %b expected 1178 dir 1", x_a, dx_a); else n_pass++;
        n_chk++; if (y_a !== 11'd798 || dy_a !== 1'b0)
            $display("FAIL bottom_bounced_y: got %0d dir %b expected 798 dir 0", y_a, dy_a); else n_pass++;
        step_a(1);
        n_chk++; if (x_a !== 11'd1180) $display("FAIL right_x: got %0d expected 1180", x_a); else n_pass++;
        n_chk++; if (dx_a !== 1'b0) $display("FAIL right_dx: got %b expected 0", dx_a); else n_pass++;
        step_a(1);
        n_chk++; if (x_a !== 11'd1178) $display("FAIL right_back_x: got %0d expected 1178", x_a); else n_pass++;
        n_chk++; if (dx_a !== 1'b0) $display("FAIL right_back_dx: got %b expected 0", dx_a); else n_pass++;
    endtask

    task automatic test_reset_mid_update();
        int agg_n;
        frame_a = 1'b1;
        tick();
        frame_a = 1'b0;
        tick();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        n_chk++; if (x_a !== 11'd590 || y_a !== 11'd462)
            $display("FAIL midrst_pos: got %0d/%0d expected 590/462", x_a, y_a); else n_pass++;
        n_chk++; if (dx_a !== 1'b1 || dy_a !== 1'b1)
            $display("FAIL midrst_dir: got %b/%b expected 1/1", dx_a, dy_a); else n_pass++;
        agg_n = (agg_a === 1'b1) ? 1 : 0;
        repeat (5) begin
            tick();
            if (agg_a === 1'b1) agg_n++;
        end
        n_chk++; if (agg_n != 0) $display("FAIL midrst_agg: got %0d pulses expected 0", agg_n); else n_pass++;
        n_chk++; if (x_a !== 11'd590) $display("FAIL midrst_hold_x: got %0d expected 590", x_a); else n_pass++;
    endtask

    task automatic test_bounce_low();
        step_b(231);
        n_chk++; if (y_b !== 11'd924 || dy_b !== 1'b1)
            $display("FAIL b_pre_bottom_y: got %0d dir %b expected 924 dir 1", y_b, dy_b); else n_pass++;
        step_b(1);
        n_chk++; if (y_b !== 11'd925 || dy_b !== 1'b0)
            $display("FAIL b_bottom_y: got %0d dir %b expected 925 dir 0", y_b, dy_b); else n_pass++;
        n_chk++; if (x_b !== 11'd1054 || dx_b !== 1'b1)
            $display("FAIL b_mid_x: got %0d dir %b expected 1054 dir 1", x_b, dx_b); else n_pass++;
        step_b(654);
        n_chk++; if (x_b !== 11'd1 || dx_b !== 1'b0)
            $display("FAIL b_pre_left_x: got %0d dir %b expected 1 dir 0", x_b, dx_b); else n_pass++;
        step_b(1);
        n_chk++; if (x_b !== 11'd0) $display("FAIL b_left_x: got %0d expected 0", x_b); else n_pass++;
        n_chk++; if (dx_b !== 1'b1) $display("FAIL b_left_dx: got %b expected 1", dx_b); else n_pass++;
    endtask

    task automatic test_frame_div();
        logic seen;
        logic exp_upd;
        for (int i = 1; i <= 6; i++) begin
            frame_c = 1'b1;
            tick();
            seen = agg_c;
            frame_c = 1'b0;
            repeat (5) begin
                tick();
                seen = seen | agg_c;
            end
            exp_upd = (i % 3 == 0);
            n_chk++; if (seen !== exp_upd)
                $display("FAIL div3_edge%0d: got update %b expected %b", i, seen, exp_upd); else n_pass++;
        end
        n_chk++; if (x_c !== 11'd594 || y_c !== 11'd466)
            $display("FAIL div3_pos: got %0d/%0d expected 594/466", x_c, y_c); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_update();
        test_pause();
        test_bounce_right();
        test_reset_mid_update();
        test_bounce_low();
        test_frame_div();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
